// File: rtl/key_event_fsm.sv
// ============================================================================
// Module      : key_event_fsm
// Description : Turns the debounced active-low key level into one-cycle
//               short-press, long-press, double-click and auto-repeat pulses.
//               Optional auto-repeat enabled by defining KEY_AUTO_REPEAT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_event_fsm #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned LONG_CNT = 125_000_000,
    parameter int unsigned DBL_CNT  = 31_250_000,
    parameter int unsigned REPT_CNT = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_kin,
    output logic o_short_press,
    output logic o_long_press,
    output logic o_dbl_click,
    output logic o_key_rpt,
    output logic o_pressed
);

    typedef enum logic [2:0] {
        S_ARM    = 3'd0,
        S_IDLE   = 3'd1,
        S_PRESS1 = 3'd2,
        S_LONG   = 3'd3,
        S_WAIT2  = 3'd4,
        S_PRESS2 = 3'd5
    } state_t;

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic c_REPT_EN = 1'b1;
`else
    localparam logic c_REPT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] c_DBL_LAST  = CNT_W'(DBL_CNT - 1);
    localparam logic [CNT_W-1:0] c_REPT_LAST = CNT_W'(REPT_CNT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_short;
    logic             r_long;
    logic             r_dbl;
    logic             r_rpt;
    logic             r_pressed;
    logic             w_short_nxt;
    logic             w_long_nxt;
    logic             w_dbl_nxt;
    logic             w_rpt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_ARM;
            r_cnt     <= '0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_dbl     <= 1'b0;
            r_rpt     <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_short   <= w_short_nxt;
            r_long    <= w_long_nxt;
            r_dbl     <= w_dbl_nxt;
            r_rpt     <= w_rpt_nxt;
            r_pressed <= ~i_kin && (r_state != S_ARM);
        end
    end

    // Each transition clears the counter; states that do not time hold it,
    // so the counter can never run past its terminal value and wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        w_dbl_nxt   = 1'b0;
        w_rpt_nxt   = 1'b0;
        case (r_state)
            S_ARM: begin
                if (i_kin) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_IDLE: begin
                if (!i_kin) begin
                    w_state_nxt = S_PRESS1;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS1: begin
                // Release takes priority over reaching the long-press threshold.
                if (i_kin) begin
                    w_state_nxt = S_WAIT2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LONG_LAST) begin
                    w_state_nxt = S_LONG;
                    w_cnt_nxt   = '0;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_LONG: begin
                if (i_kin) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (c_REPT_EN) begin
                    if (r_cnt == c_REPT_LAST) begin
                        w_cnt_nxt = '0;
                        w_rpt_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_WAIT2: begin
                // A second press on the timeout cycle still counts as a double click.
                if (!i_kin) begin
                    w_state_nxt = S_PRESS2;
                    w_cnt_nxt   = '0;
                    w_dbl_nxt   = 1'b1;
                end else if (r_cnt == c_DBL_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_short_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_PRESS2: begin
                if (i_kin) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_ARM;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_short_press = r_short;
    assign o_long_press  = r_long;
    assign o_dbl_click   = r_dbl;
    assign o_key_rpt     = r_rpt;
    assign o_pressed     = r_pressed;

endmodule

`default_nettype wire

// File: tb/tb_key_event_fsm.sv
// ============================================================================
// Module      : tb_key_event_fsm
// Description : Directed bench for key_event_fsm (LONG=20, DBL=8, REPT=5).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_event_fsm;

    logic clk;
    logic rst;
    logic i_kin;
    logic o_short_press;
    logic o_long_press;
    logic o_dbl_click;
    logic o_key_rpt;
    logic o_pressed;

    int n_tests;
    int n_fail;
    int cyc;
    int n_short, n_long, n_dbl, n_rpt, n_multi, n_phi;
    int t_short, t_long, t_dbl, t_rpt_first, t_rpt_last;

    key_event_fsm #(
        .CNT_W    (32),
        .LONG_CNT (20),
        .DBL_CNT  (8),
        .REPT_CNT (5)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_kin         (i_kin),
        .o_short_press (o_short_press),
        .o_long_press  (o_long_press),
        .o_dbl_click   (o_dbl_click),
        .o_key_rpt     (o_key_rpt),
        .o_pressed     (o_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_tally();
        cyc = 0;
        n_short = 0; n_long = 0; n_dbl = 0; n_rpt = 0; n_multi = 0; n_phi = 0;
        t_short = -1; t_long = -1; t_dbl = -1; t_rpt_first = -1; t_rpt_last = -1;
    endtask

    // Drive kin for n cycles; cycle k is the value seen just after the k-th edge.
    task automatic run(input logic k, input int n);
        for (int i = 0; i < n; i++) begin
            i_kin = k;
            @(posedge clk);
            #1;
            cyc++;
            if (o_short_press) begin n_short++; t_short = cyc; end
            if (o_long_press)  begin n_long++;  t_long  = cyc; end
            if (o_dbl_click)   begin n_dbl++;   t_dbl   = cyc; end
            if (o_key_rpt) begin
                n_rpt++;
                if (t_rpt_first < 0) t_rpt_first = cyc;
                t_rpt_last = cyc;
            end
            if ((int'(o_short_press) + int'(o_long_press) + int'(o_dbl_click) + int'(o_key_rpt)) > 1)
                n_multi++;
            if (o_pressed) n_phi++;
        end
    endtask

    function automatic int out_sum();
        return int'(o_short_press) + int'(o_long_press) + int'(o_dbl_click)
             + int'(o_key_rpt) + int'(o_pressed);
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        i_kin   = 1'b0;
        clear_tally();

        // 1: key held through reset produces nothing until it is released
        run(1'b0, 3);
        check("rst_outputs", out_sum(), 0);
        rst = 1'b0;
        clear_tally();
        run(1'b0, 40);
        check("t1_pulses", n_short + n_long + n_dbl + n_rpt, 0);
        check("t1_pressed", n_phi, 0);
        clear_tally();
        run(1'b1, 5);
        check("t1_release_pulses", n_short + n_long + n_dbl + n_rpt + n_phi, 0);

        // 2: single short press
        clear_tally();
        run(1'b0, 5);
        run(1'b1, 20);
        check("t2_short_cnt", n_short, 1);
        check("t2_short_cyc", t_short, 14);
        check("t2_others", n_long + n_dbl + n_rpt, 0);
        check("t2_pressed", n_phi, 5);

        // 3: double click
        clear_tally();
        run(1'b0, 5);
        run(1'b1, 3);
        run(1'b0, 5);
        run(1'b1, 15);
        check("t3_dbl_cnt", n_dbl, 1);
        check("t3_dbl_cyc", t_dbl, 9);
        check("t3_others", n_short + n_long + n_rpt, 0);

        // 4: long press with optional auto-repeat
        clear_tally();
        run(1'b0, 32);
        run(1'b1, 15);
        check("t4_long_cnt", n_long, 1);
        check("t4_long_cyc", t_long, 21);
        check("t4_short_dbl", n_short + n_dbl, 0);
        check("t4_pressed", n_phi, 32);
`ifdef KEY_AUTO_REPEAT_EN
        check("t4_rpt_cnt", n_rpt, 2);
        check("t4_rpt_first", t_rpt_first, 26);
        check("t4_rpt_last", t_rpt_last, 31);
`else
        check("t4_rpt_cnt", n_rpt, 0);
`endif

        // 5: release on the long-press threshold cycle takes the short path
        clear_tally();
        run(1'b0, 20);
        run(1'b1, 15);
        check("t5_long_cnt", n_long, 0);
        check("t5_short_cnt", n_short, 1);
        check("t5_short_cyc", t_short, 29);

        // 7: second press exactly on the window timeout cycle
        clear_tally();
        run(1'b0, 5);
        run(1'b1, 8);
        run(1'b0, 3);
        run(1'b1, 15);
        check("t7_dbl_cyc", t_dbl, 14);
        check("t7_short_cnt", n_short, 0);
        check("t7_multi", n_multi, 0);

        // 6: reset in WAIT2 aborts the pending short press
        clear_tally();
        run(1'b0, 5);
        run(1'b1, 5);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", out_sum(), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_tally();
        run(1'b1, 20);
        check("t6_no_short", n_short + n_long + n_dbl + n_rpt, 0);

        // 6b: asynchronous reset clears a live long_press/pressed at once
        clear_tally();
        run(1'b0, 21);
        check("t6b_long_live", int'(o_long_press), 1);
        check("t6b_pressed_live", int'(o_pressed), 1);
        rst = 1'b1;
        #1;
        check("t6b_rst_outputs", out_sum(), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_tally();
        run(1'b0, 10);
        run(1'b1, 5);
        check("t6b_after_rst", n_short + n_long + n_dbl + n_rpt + n_phi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
